button_events: RTL

BUTTON_EVENTS -- requirements
Module: button_events

---
 rtl/button_events.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/button_events.sv
// button_events
//   Classifies debounced press/release pulses into click, double click,
//   long press and auto-repeat events. One shared down-stream counter times
//   every state; it is cleared on each state change and only ever compared
//   for equality against (parameter - 1), so it can never wrap.
//
// State table
//   state  | meaning
//   IDLE   | button released, nothing pending
//   PRESS1 | first press held, timing toward a long press
//   WAIT2  | first press released, timing the double-click window
//   PRESS2 | second press held, double click fires on its release
//   LONG   | long press reached, emitting auto-repeat pulses
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   up_i     in   one-cycle debounced press pulse
//   dn_i     in   one-cycle debounced release pulse
//   click_o  out  one-cycle single-click pulse
//   dclick_o out  one-cycle double-click pulse
//   long_o   out  one-cycle pulse when a press reaches LONG_CYCLES
//   rpt_o    out  one-cycle auto-repeat pulse while a long press is held
//   busy_o   out  high whenever the FSM is not in IDLE
module button_events #(
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int DCLICK_CYCLES = 12_500_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic up_i,
  input  logic dn_i,
  output logic click_o,
  output logic dclick_o,
  output logic long_o,
  output logic rpt_o,
  output logic busy_o
);

  if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_events: every cycle parameter must be at least 2");
  end

  localparam int MAX_LD = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int MAX_ALL = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_ALL);

  // The counter holds (edges since entry - 1), so the Nth edge is cnt == N-1.
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          click_nx, dclick_nx, long_nx, rpt_nx;
  logic          up_ev, dn_ev;

  // Press and release in the same cycle cancel out.
  assign up_ev = up_i & ~dn_i;
  assign dn_ev = dn_i & ~up_i;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + 1'b1;
    click_nx  = 1'b0;
    dclick_nx = 1'b0;
    long_nx   = 1'b0;
    rpt_nx    = 1'b0;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (up_ev) state_nx = PRESS1;
      end

      PRESS1: begin
        if (dn_ev) begin
          state_nx = WAIT2;
          cnt_nx   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nx = LONG;
          cnt_nx   = '0;
          long_nx  = 1'b1;
        end
      end

      WAIT2: begin
        if (up_ev) begin
          state_nx = PRESS2;
          cnt_nx   = '0;
        end else if (cnt == DCLICK_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          click_nx = 1'b1;
        end
      end

      PRESS2: begin
        // Hold duration does not matter here, so the counter stays parked.
        cnt_nx = '0;
        if (dn_ev) begin
          state_nx  = IDLE;
          dclick_nx = 1'b1;
        end
      end

      LONG: begin
        if (dn_ev) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == REPEAT_LAST) begin
          cnt_nx = '0;
          rpt_nx = 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      click_o  <= 1'b0;
      dclick_o <= 1'b0;
      long_o   <= 1'b0;
      rpt_o    <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      click_o  <= click_nx;
      dclick_o <= dclick_nx;
      long_o   <= long_nx;
      rpt_o    <= rpt_nx;
      busy_o   <= (state_nx != IDLE);
    end
  end

endmodule
